seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width (legal 8..64, even).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  operation request, sampled only when ready.
REQ-005 SHALL have port ALUControl  input  4  opcode: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 umul, 0101 smul, 0110 udiv, 0111 sdiv.
REQ-006 SHALL have port a  input  WIDTH  first operand / dividend.
REQ-007 SHALL have port b  input  WIDTH  second operand / divisor.
REQ-008 SHALL have port ready  output  1  high in IDLE; start accepted only when high.
REQ-009 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-010 SHALL have port Result  output  WIDTH  low product, sum/logic result, or quotient.
REQ-011 SHALL have port Result64  output  2*WIDTH  full product; for divide {remainder, quotient}; else zero-extended Result.
REQ-012 SHALL have port ALUFlags  output  4  {N,Z,C,V}.

Function
REQ-013 SHALL capture a, b and ALUControl on the accepted start edge; later input changes SHALL NOT affect the operation.
REQ-014 FSM states IDLE, MUL, DIV, DONE; IDLE->DONE for opcodes 0000-0011 and unsupported opcodes, IDLE->MUL for 0100/0101, IDLE->DIV for 0110/0111; MUL/DIV->DONE after WIDTH iteration cycles; DONE->IDLE unconditionally.
REQ-015 Start accepted at edge T: done high in cycle after T for add/sub/and/or; high WIDTH+1 cycles after T for mul/div.
REQ-016 ready SHALL be low in MUL, DIV and DONE; start while not ready SHALL be ignored, no queuing.
REQ-017 Result, Result64, ALUFlags SHALL be registered, updated only on entry to DONE, held until the next DONE.
REQ-018 Add/sub: WIDTH-bit wrap; C = carry out (add) or NOT borrow (sub); V = signed overflow; N = Result MSB; Z = Result all-zero.
REQ-019 And/or: N, Z from Result; C=V=0.
REQ-020 Multiply: shift-add, one partial product per cycle; smul operates on magnitudes and negates the 2*WIDTH product when operand signs differ; N = Result64 MSB; Z = Result64 all-zero; C=V=0.
REQ-021 Divide: restoring, one quotient bit per cycle; sdiv quotient truncates toward zero, remainder takes dividend sign; N, Z from quotient; C=0.
REQ-022 Divide by zero: quotient all-ones, remainder = a, V=1, latency unchanged; sdiv of most-negative by -1: quotient = a, remainder 0, V=1.
REQ-023 Unsupported opcode: Result=0, Result64=0, ALUFlags=0, done after one cycle; no X SHALL ever reach outputs.

Reset
REQ-024 Reset SHALL force IDLE, ready=1, done=0, Result=0, Result64=0, ALUFlags=0, iteration counter=0.
REQ-025 Reset asserted mid-MUL/DIV SHALL abort the operation with no done pulse; reset SHALL take priority over a simultaneous start.

Configuration
REQ-026 Macro SEQ_ALU_DIV_EN defined: opcodes 0110/0111 and the DIV state SHALL be implemented per REQ-021/022.
REQ-027 SEQ_ALU_DIV_EN undefined: DIV state and divider logic SHALL be absent; 0110/0111 SHALL behave as unsupported opcodes per REQ-023.

Structure
REQ-028 Package seq_alu_pkg SHALL hold the opcode localparams and the FSM state enum typedef.
REQ-029 The iterative datapath (accumulator, shift registers, counter, sign fix-up) SHALL be a sub-module seq_muldiv; seq_alu holds the FSM, single-cycle ops and output registers.

Verification (WIDTH=32)
REQ-030 add a=0x7FFFFFFF, b=1 -> done at T+1, Result=0x80000000, flags N=1 Z=0 C=0 V=1; sub a=5, b=5 -> Result=0, Z=1, C=1.
REQ-031 smul a=-3, b=7 -> done at T+33, Result64=0xFFFFFFFFFFFFFFEB, N=1; umul a=b=0xFFFFFFFF -> Result64=0xFFFFFFFE00000001.
REQ-032 sdiv a=-7, b=2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, V=0; udiv a=9, b=0 -> quotient 0xFFFFFFFF, remainder 9, V=1.
REQ-033 start pulsed at T+5 during umul -> ignored, single done at T+33; new start in DONE cycle ignored, start next IDLE cycle accepted.
REQ-034 reset at T+10 during umul -> no done, all outputs zero, ready=1 next cycle; following add completes normally.
REQ-035 build without SEQ_ALU_DIV_EN, opcode 0110 -> done at T+1, Result=0, ALUFlags=0.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro used by this design: SEQ_ALU_DIV_EN (enables udiv/sdiv).
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_UMUL = 4'b0100;
  localparam logic [3:0] OP_SMUL = 4'b0101;
  localparam logic [3:0] OP_UDIV = 4'b0110;
  localparam logic [3:0] OP_SDIV = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Signed variants of the iterative ops work on operand magnitudes.
  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == OP_SMUL) || (op == OP_SDIV);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative shift-add multiplier and restoring divider sharing one 2*WIDTH shift register.
// Latency: WIDTH step cycles after load; res64_o shows the fixed-up result of the step in progress.
// Backpressure: none; the controlling FSM decides when to load and step.
// Ports: clk/reset (sync, active-high); load_i captures operands; step_i runs one iteration;
//        div_i selects divide (only with SEQ_ALU_DIV_EN); sgn_i selects signed operation;
//        last_o flags the final iteration; res64_o full product or {remainder, quotient};
//        ovf_o divide overflow / divide-by-zero (only with SEQ_ALU_DIV_EN).
module seq_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
`ifdef SEQ_ALU_DIV_EN
  input  logic               div_i,
  output logic               ovf_o,
`endif
  input  logic               sgn_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] res64_o
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] p_q, p_d;     // mul: {acc_hi, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   m_q;          // multiplicand or divisor magnitude
  logic [CW-1:0]      cnt_q;
  logic               neg_q;        // negate product / quotient at the end
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     hi_sum;

`ifdef SEQ_ALU_DIV_EN
  logic               div_q;
  logic               rneg_q;       // remainder follows the dividend sign
  logic               div0_q;
  logic               ovf_q;
  logic [WIDTH-1:0]   a_q;          // original dividend, returned as remainder on divide-by-zero
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   trial;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   min_neg;

  assign min_neg = {1'b1, {(WIDTH-1){1'b0}}};
  assign ovf_o   = ovf_q;
`endif

  assign mag_a  = (sgn_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b  = (sgn_i && b_i[WIDTH-1]) ? -b_i : b_i;
  assign last_o = (cnt_q == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      div_q  <= 1'b0;
      rneg_q <= 1'b0;
      div0_q <= 1'b0;
      ovf_q  <= 1'b0;
      a_q    <= '0;
`endif
    end else if (load_i) begin
      cnt_q <= '0;
      neg_q <= sgn_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
`ifdef SEQ_ALU_DIV_EN
      p_q    <= {{WIDTH{1'b0}}, (div_i ? mag_a : mag_b)};
      m_q    <= div_i ? mag_b : mag_a;
      div_q  <= div_i;
      rneg_q <= sgn_i & a_i[WIDTH-1];
      div0_q <= (b_i == '0);
      ovf_q  <= (b_i == '0) | (sgn_i && (a_i == min_neg) && (b_i == '1));
      a_q    <= a_i;
`else
      p_q    <= {{WIDTH{1'b0}}, mag_b};
      m_q    <= mag_a;
`endif
    end else if (step_i) begin
      p_q   <= p_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // One iteration: multiply adds the multiplicand into the high half when the
  // multiplier LSB is set, then shifts right (carry goes into the MSB).
  // Divide shifts {rem, quo} left and keeps the trial subtraction if it fits.
  always_comb begin
    hi_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    p_d    = {hi_sum, p_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    rem_sh = p_q[2*WIDTH-1:WIDTH-1];
    trial  = rem_sh[WIDTH-1:0] - m_q;
    if (div_q) begin
      if (rem_sh >= {1'b0, m_q}) begin
        p_d = {trial, p_q[WIDTH-2:0], 1'b1};
      end else begin
        p_d = {rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Sign fix-up applied to the post-step value so the FSM can register the
  // final answer on the same edge as the last iteration.
  always_comb begin
    res64_o = neg_q ? -p_d : p_d;
`ifdef SEQ_ALU_DIV_EN
    quo = p_d[WIDTH-1:0];
    rem = p_d[2*WIDTH-1:WIDTH];
    if (neg_q) quo = -quo;
    if (rneg_q) rem = -rem;
    if (div0_q) begin
      quo = '1;
      rem = a_q;
    end
    if (div_q) res64_o = {rem, quo};
`endif
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/and/or, iterative mul (and div with SEQ_ALU_DIV_EN).
// Latency: done one cycle after accept for add/sub/and/or/unsupported, WIDTH+1 cycles for mul/div.
// Backpressure: ready low while busy or in DONE; start without ready is dropped, never queued.
// Ports: clk, reset (sync, active-high), start, ALUControl[3:0], a, b ->
//        ready, done (1-cycle pulse), Result, Result64 (2*WIDTH), ALUFlags {N,Z,C,V}.
// Macro: SEQ_ALU_DIV_EN enables opcodes 0110/0111 and the DIV state.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         ALUControl,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [WIDTH-1:0]   Result,
  output logic [2*WIDTH-1:0] Result64,
  output logic [3:0]         ALUFlags
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2*WIDTH-1:0] r64_q, r64_d;
  logic [3:0]         flags_q, flags_d;
  logic               upd;

  logic [WIDTH:0]     sum, diff;
  logic               add_v, sub_v;
  logic [WIDTH-1:0]   and_r, or_r;

  logic               md_load, md_step, md_last;
  logic [2*WIDTH-1:0] md_res64;
`ifdef SEQ_ALU_DIV_EN
  logic               md_div, md_ovf;
`endif

  // Subtract as a + ~b + 1 so the carry out is directly NOT borrow.
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign add_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign and_r = a & b;
  assign or_r  = a | b;

  assign md_step = (state_q == S_MUL) || (state_q == S_DIV);

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .load_i  (md_load),
    .step_i  (md_step),
`ifdef SEQ_ALU_DIV_EN
    .div_i   (md_div),
    .ovf_o   (md_ovf),
`endif
    .sgn_i   (op_is_signed(ALUControl)),
    .a_i     (a),
    .b_i     (b),
    .last_o  (md_last),
    .res64_o (md_res64)
  );

  always_comb begin
    state_d  = state_q;
    upd      = 1'b0;
    result_d = '0;
    r64_d    = '0;
    flags_d  = '0;
    md_load  = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    md_div   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (ALUControl)
            OP_ADD: begin
              state_d  = S_DONE;
              upd      = 1'b1;
              result_d = sum[WIDTH-1:0];
              flags_d  = {sum[WIDTH-1], (sum[WIDTH-1:0] == '0), sum[WIDTH], add_v};
            end
            OP_SUB: begin
              state_d  = S_DONE;
              upd      = 1'b1;
              result_d = diff[WIDTH-1:0];
              flags_d  = {diff[WIDTH-1], (diff[WIDTH-1:0] == '0), diff[WIDTH], sub_v};
            end
            OP_AND: begin
              state_d  = S_DONE;
              upd      = 1'b1;
              result_d = and_r;
              flags_d  = {and_r[WIDTH-1], (and_r == '0), 2'b00};
            end
            OP_OR: begin
              state_d  = S_DONE;
              upd      = 1'b1;
              result_d = or_r;
              flags_d  = {or_r[WIDTH-1], (or_r == '0), 2'b00};
            end
            OP_UMUL, OP_SMUL: begin
              state_d = S_MUL;
              md_load = 1'b1;
            end
`ifdef SEQ_ALU_DIV_EN
            OP_UDIV, OP_SDIV: begin
              state_d = S_DIV;
              md_load = 1'b1;
              md_div  = 1'b1;
            end
`endif
            default: begin
              // Unsupported: finish next cycle with all-zero outputs.
              state_d = S_DONE;
              upd     = 1'b1;
            end
          endcase
          r64_d = {{WIDTH{1'b0}}, result_d};
        end
      end
      S_MUL: begin
        if (md_last) begin
          state_d  = S_DONE;
          upd      = 1'b1;
          result_d = md_res64[WIDTH-1:0];
          r64_d    = md_res64;
          flags_d  = {md_res64[2*WIDTH-1], (md_res64 == '0), 2'b00};
        end
      end
`ifdef SEQ_ALU_DIV_EN
      S_DIV: begin
        if (md_last) begin
          state_d  = S_DONE;
          upd      = 1'b1;
          result_d = md_res64[WIDTH-1:0];
          r64_d    = md_res64;
          flags_d  = {md_res64[WIDTH-1], (md_res64[WIDTH-1:0] == '0), 1'b0, md_ovf};
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      r64_q    <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      if (upd) begin
        result_q <= result_d;
        r64_q    <= r64_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign done     = (state_q == S_DONE);
  assign Result   = result_q;
  assign Result64 = r64_q;
  assign ALUFlags = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu (WIDTH=32): vector table plus hand-written sequences.
// Latency: checks done timing relative to the accepting clock edge.
// Backpressure: checks start is ignored while ready is low.
module tb_seq_alu;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [3:0]     ALUControl;
  logic [W-1:0]   a, b;
  logic           ready, done;
  logic [W-1:0]   Result;
  logic [2*W-1:0] Result64;
  logic [3:0]     ALUFlags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ALUControl (ALUControl),
    .a          (a),
    .b          (b),
    .ready      (ready),
    .done       (done),
    .Result     (Result),
    .Result64   (Result64),
    .ALUFlags   (ALUFlags)
  );

  typedef struct {
    logic [3:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    int             lat;
    logic [W-1:0]   res;
    logic [2*W-1:0] r64;
    logic [3:0]     fl;
    string          name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                      input int lat, input logic [W-1:0] res, input logic [2*W-1:0] r64,
                      input logic [3:0] fl, input string name);
    vec_t v;
    v.op = op; v.a = va; v.b = vb; v.lat = lat;
    v.res = res; v.r64 = r64; v.fl = fl; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, " ready_before_start"}, ready, 1);
  endtask

  task automatic run_op(input vec_t v);
    int first = 0;
    int ndone = 0;
    logic [W-1:0]   got_res = '0;
    logic [2*W-1:0] got_r64 = '0;
    logic [3:0]     got_fl  = '0;
    wait_ready(v.name);
    ALUControl = v.op; a = v.a; b = v.b; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= v.lat + 3; n++) begin
      @(negedge clk);
      if (n == 1) begin
        // Scramble inputs: the captured operands must be the ones used.
        start = 1'b0;
        a = $urandom; b = $urandom; ALUControl = 4'($urandom_range(0, 15));
        chk({v.name, " ready_low_after_accept"}, ready, 0);
      end
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = n; got_res = Result; got_r64 = Result64; got_fl = ALUFlags;
        end
      end
    end
    chk({v.name, " latency"}, first, v.lat);
    chk({v.name, " done_pulses"}, ndone, 1);
    chk({v.name, " Result"}, got_res, v.res);
    chk({v.name, " Result64"}, got_r64, v.r64);
    chk({v.name, " ALUFlags"}, got_fl, v.fl);
    chk({v.name, " Result_held"}, Result, v.res);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; ALUControl = 4'h0; a = '0; b = '0;

    // Single-cycle and multiply vectors, hand-computed for WIDTH=32.
    push(4'h0, 32'h7FFFFFFF, 32'h1, 1, 32'h80000000, 64'h80000000, 4'b1001, "add_ovf");
    push(4'h1, 32'h5, 32'h5, 1, 32'h0, 64'h0, 4'b0110, "sub_equal");
    push(4'h0, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 64'h0, 4'b0110, "add_carry");
    push(4'h1, 32'h3, 32'h5, 1, 32'hFFFFFFFE, 64'hFFFFFFFE, 4'b1000, "sub_borrow");
    push(4'h1, 32'h80000000, 32'h1, 1, 32'h7FFFFFFF, 64'h7FFFFFFF, 4'b0011, "sub_ovf");
    push(4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hF000F000, 64'hF000F000, 4'b1000, "and");
    push(4'h3, 32'h0, 32'h0, 1, 32'h0, 64'h0, 4'b0100, "or_zero");
    push(4'h3, 32'h00FF0000, 32'h0000000F, 1, 32'h00FF000F, 64'h00FF000F, 4'b0000, "or");
    push(4'h5, 32'hFFFFFFFD, 32'h7, 33, 32'hFFFFFFEB, 64'hFFFFFFFFFFFFFFEB, 4'b1000, "smul_neg3_7");
    push(4'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000001, 64'hFFFFFFFE00000001, 4'b1000, "umul_max");
    push(4'h4, 32'h0, 32'h5, 33, 32'h0, 64'h0, 4'b0100, "umul_zero");
    push(4'h5, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 32'h6, 64'h6, 4'b0000, "smul_neg_neg");
    push(4'h8, 32'h12345678, 32'h9ABCDEF0, 1, 32'h0, 64'h0, 4'b0000, "unsupported_8");
    push(4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h0, 64'h0, 4'b0000, "unsupported_F");
`ifdef SEQ_ALU_DIV_EN
    push(4'h6, 32'h9, 32'h0, 33, 32'hFFFFFFFF, 64'h00000009FFFFFFFF, 4'b1001, "udiv_by_zero");
    push(4'h7, 32'hFFFFFFF9, 32'h2, 33, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFFD, 4'b1000, "sdiv_neg7_2");
    push(4'h7, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 64'h0000000080000000, 4'b1001, "sdiv_min_neg1");
    push(4'h6, 32'd100, 32'd7, 33, 32'd14, 64'h000000020000000E, 4'b0000, "udiv_100_7");
`else
    push(4'h6, 32'h9, 32'h0, 1, 32'h0, 64'h0, 4'b0000, "udiv_absent");
    push(4'h7, 32'hFFFFFFF9, 32'h2, 1, 32'h0, 64'h0, 4'b0000, "sdiv_absent");
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", ready, 1);
    chk("reset done", done, 0);
    chk("reset Result", Result, 0);
    chk("reset Result64", Result64, 0);
    chk("reset ALUFlags", ALUFlags, 0);
    reset = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Start during multiply is dropped; start in DONE is dropped; next IDLE start is taken.
    wait_ready("busy_start");
    ALUControl = 4'h4; a = 32'h10; b = 32'h20; start = 1'b1;
    @(posedge clk);
    ndone = 0;
    for (int n = 1; n <= 35; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 5) begin
        start = 1'b1; ALUControl = 4'h0; a = 32'h1; b = 32'h1;
      end
      if (n == 6) start = 1'b0;
      if (n <= 33 && done) ndone++;
      if (n == 32) chk("busy_start no_early_done", done, 0);
      if (n == 33) begin
        chk("busy_start done_at_33", done, 1);
        chk("busy_start Result64", Result64, 64'h200);
        ALUControl = 4'h0; a = 32'h1; b = 32'h2; start = 1'b1;
      end
      if (n == 34) begin
        chk("done_cycle_start ignored", done, 0);
        chk("done_cycle_start ready", ready, 1);
      end
      if (n == 35) begin
        start = 1'b0;
        chk("idle_start done", done, 1);
        chk("idle_start Result", Result, 32'h3);
      end
    end
    chk("busy_start single_done", ndone, 1);

    // Reset at T+10 of a multiply aborts it with no done pulse.
    wait_ready("mid_reset");
    ALUControl = 4'h4; a = 32'hFFFFFFFF; b = 32'h2; start = 1'b1;
    @(posedge clk);
    ndone = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 10) reset = 1'b1;
      if (n == 11) begin
        reset = 1'b0;
        chk("mid_reset ready", ready, 1);
        chk("mid_reset Result", Result, 0);
        chk("mid_reset Result64", Result64, 0);
        chk("mid_reset ALUFlags", ALUFlags, 0);
      end
      if (done) ndone++;
    end
    chk("mid_reset no_done", ndone, 0);
    begin
      vec_t v;
      v.op = 4'h0; v.a = 32'h2; v.b = 32'h3; v.lat = 1;
      v.res = 32'h5; v.r64 = 64'h5; v.fl = 4'b0000; v.name = "add_after_reset";
      run_op(v);
    end

    // Reset wins over a simultaneous start.
    wait_ready("reset_vs_start");
    reset = 1'b1; start = 1'b1; ALUControl = 4'h0; a = 32'h1; b = 32'h1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("reset_vs_start done", done, 0);
    chk("reset_vs_start ready", ready, 1);
    chk("reset_vs_start Result", Result, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
